// File: rtl/gray_sink_pkg.sv
// Shared defaults, FIFO entry layout and tag positions for the gray frame sink.
package gray_sink_pkg;

    localparam int DEF_IMG_W      = 1280;
    localparam int DEF_IMG_H      = 720;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int ENTRY_W        = 35;
    localparam int TAG_SOF        = 32;
    localparam int TAG_EOL        = 33;
    localparam int TAG_EOF        = 34;

    function automatic logic [ENTRY_W-1:0] mk_entry(
        input logic        eof,
        input logic        eol,
        input logic        sof,
        input logic [31:0] word
    );
        return {eof, eol, sof, word};
    endfunction

endpackage

// File: rtl/gray_sink_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module gray_sink_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gray_frame_sink.sv
// Packs gray pixels into tagged 32-bit words and buffers them for a writer.
// Define FRAME_SUM_EN to add the per-frame pixel sum outputs.
module gray_frame_sink
    import gray_sink_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gray_in,
    input  logic        valid_in,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] frame_cnt,
    output logic [31:0] frame_sum,
    output logic        frame_sum_vld
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        pack_q;
    logic               overflow_q;
    logic [15:0]        frame_cnt_q;
    logic               last_x, last_y, last_px;
    logic               push, pop, drop;
    logic               sof, eol, eof;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;

    assign last_x  = (x_q == XW'(IMG_W - 1));
    assign last_y  = (y_q == YW'(IMG_H - 1));
    assign last_px = valid_in && last_x && last_y;

    // Lane 3 carries the group's last pixel, so x=3 identifies the frame's first word.
    assign sof      = (y_q == '0) && (x_q == XW'(3));
    assign eol      = last_x;
    assign eof      = last_x && last_y;
    assign wr_entry = mk_entry(eof, eol, sof, {gray_in, pack_q});

    assign push = valid_in && (lane_q == 2'd3);
    assign pop  = out_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lane_d = lane_q;
        if (valid_in) begin
            lane_d = lane_q + 2'd1;
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            lane_q <= lane_d;
            if (valid_in) begin
                unique case (lane_q)
                    2'd0:    pack_q[7:0]   <= gray_in;
                    2'd1:    pack_q[15:8]  <= gray_in;
                    2'd2:    pack_q[23:16] <= gray_in;
                    default: pack_q        <= pack_q;
                endcase
            end
            if (last_px) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    gray_sink_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (wr_entry),
        .pop_i   (pop),
        .dout_o  (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_empty ? 32'd0 : rd_entry[31:0];
    assign out_sof   = !fifo_empty && rd_entry[TAG_SOF];
    assign out_eol   = !fifo_empty && rd_entry[TAG_EOL];
    assign out_eof   = !fifo_empty && rd_entry[TAG_EOF];
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

`ifdef FRAME_SUM_EN
    logic [31:0] acc_q;
    logic [31:0] sum_q;
    logic        sum_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            sum_vld_q <= 1'b0;
            if (last_px) begin
                sum_q     <= acc_q + 32'(gray_in);
                sum_vld_q <= 1'b1;
                acc_q     <= '0;
            end else if (valid_in) begin
                acc_q <= acc_q + 32'(gray_in);
            end
        end
    end

    assign frame_sum     = sum_q;
    assign frame_sum_vld = sum_vld_q;
`else
    assign frame_sum     = 32'd0;
    assign frame_sum_vld = 1'b0;
`endif

endmodule

// File: tb/tb_gray_frame_sink.sv
// Directed bench for gray_frame_sink with an 8x2 frame and a 4-entry FIFO.
module tb_gray_frame_sink;

    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gray_in;
    logic        valid_in;
    logic [31:0] out_data;
    logic        out_sof, out_eol, out_eof, out_valid;
    logic        out_ready;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic [31:0] frame_sum;
    logic        frame_sum_vld;

    int checks   = 0;
    int failures = 0;
    int vld_cnt  = 0;
    logic [34:0] cap_q[$];
    logic [34:0] exp_w[4];

    gray_frame_sink #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .gray_in       (gray_in),
        .valid_in      (valid_in),
        .out_data      (out_data),
        .out_sof       (out_sof),
        .out_eol       (out_eol),
        .out_eof       (out_eof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .frame_cnt     (frame_cnt),
        .frame_sum     (frame_sum),
        .frame_sum_vld (frame_sum_vld)
    );

    always #5 clk = ~clk;

    // Words are popped on the next rising edge when seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            cap_q.push_back({out_eof, out_eol, out_sof, out_data});
        end
        if (frame_sum_vld) begin
            vld_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cap(input int i);
        if (i < cap_q.size()) return 64'(cap_q[i]);
        return 64'hBAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] head();
        return 64'({out_eof, out_eol, out_sof, out_data});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] v);
        gray_in  = v;
        valid_in = 1'b1;
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        tick(2);
        rst = 1'b0;
        cap_q.delete();
    endtask

    initial begin
        exp_w[0] = 35'h1_0302_0100;
        exp_w[1] = 35'h2_0706_0504;
        exp_w[2] = 35'h0_0B0A_0908;
        exp_w[3] = 35'h6_0F0E_0D0C;
        rst       = 1'b1;
        gray_in   = '0;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        tick(1);
        do_reset();

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", head(), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_fcnt", 64'(frame_cnt), 64'd0);
        check("rst_sum", 64'(frame_sum), 64'd0);
        check("rst_svld", 64'(frame_sum_vld), 64'd0);

        // 1: continuous stream
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) pix(8'(i));
        tick(3);
        check("t1_nwords", 64'(cap_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t1_w%0d", k), cap(k), 64'(exp_w[k]));
        check("t1_fcnt", 64'(frame_cnt), 64'd1);
        check("t1_empty", 64'(out_valid), 64'd0);

        // 2: valid toggling, word visible one cycle after lane 3
        cap_q.delete();
        for (int i = 0; i < 16; i++) begin
            pix(8'(i));
            if (i % 4 == 3) begin
                check($sformatf("t2_lat_v%0d", i / 4), 64'(out_valid), 64'd1);
                check($sformatf("t2_lat_w%0d", i / 4), head(), 64'(exp_w[i / 4]));
            end
            tick(1);
        end
        tick(2);
        check("t2_nwords", 64'(cap_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t2_w%0d", k), cap(k), 64'(exp_w[k]));
        check("t2_fcnt", 64'(frame_cnt), 64'd2);

        // 3: overflow with stalled consumer
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) pix(8'(i));
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_head", head(), 64'(exp_w[0]));
        check("t3_fcnt", 64'(frame_cnt), 64'd1);
        tick(3);
        check("t3_hold", head(), 64'(exp_w[0]));
        check("t3_none", 64'(cap_q.size()), 64'd0);
        out_ready = 1'b1;
        tick(6);
        check("t3_nwords", 64'(cap_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t3_w%0d", k), cap(k), 64'(exp_w[k]));
        check("t3_ovf_sticky", 64'(overflow), 64'd1);
        check("t3_drained", 64'(out_valid), 64'd0);

        // 4: full FIFO, pop and push on the same edge
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++) pix(8'(i));
        out_ready = 1'b1;
        pix(8'd19);
        out_ready = 1'b0;
        check("t4_ovf", 64'(overflow), 64'd0);
        check("t4_head", head(), 64'(exp_w[1]));
        out_ready = 1'b1;
        tick(8);
        check("t4_nwords", 64'(cap_q.size()), 64'd5);
        for (int k = 0; k < 4; k++) check($sformatf("t4_w%0d", k), cap(k), 64'(exp_w[k]));
        check("t4_w4", cap(4), 64'h1_1312_1110);
        check("t4_ovf_end", 64'(overflow), 64'd0);

        // 5: reset mid-frame
        do_reset();
        for (int i = 0; i < 6; i++) pix(8'(i));
        do_reset();
        for (int i = 0; i < 16; i++) pix(8'(8'h10 + i));
        tick(3);
        check("t5_nwords", 64'(cap_q.size()), 64'd4);
        check("t5_first", cap(0), 64'h1_1312_1110);
        check("t5_last", cap(3), 64'h6_1F1E_1D1C);
        check("t5_fcnt", 64'(frame_cnt), 64'd1);

        // 6: frame sum over two all-0xFF frames
        do_reset();
        vld_cnt = 0;
        for (int i = 0; i < 32; i++) pix(8'hFF);
        tick(3);
        check("t6_fcnt", 64'(frame_cnt), 64'd2);
`ifdef FRAME_SUM_EN
        check("t6_sum", 64'(frame_sum), 64'h0FF0);
        check("t6_pulses", 64'(vld_cnt), 64'd2);
`else
        check("t6_sum", 64'(frame_sum), 64'd0);
        check("t6_pulses", 64'(vld_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
